// File: rtl/phy_pkg.sv
// Purpose: shared PHY receiver definitions (state encoding, default symbols).
// Contents:
//   rx_state_t - receiver FSM states HUNT / ALIGN / LOCKED
//   COMMA_SYM  - default 8-bit alignment symbol
//   IDLE_SYM   - default 8-bit idle symbol
package phy_pkg;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_ALIGN  = 2'd1,
        ST_LOCKED = 2'd2
    } rx_state_t;

    localparam logic [7:0] COMMA_SYM = 8'hBC;
    localparam logic [7:0] IDLE_SYM  = 8'h7C;

endpackage

// File: rtl/serial_paralelo_sync_if.sv
// Purpose: serial input / parallel output bundle of the receiver.
// Signals:
//   data_in  - serial bit stream, MSB first (source -> receiver)
//   data_out - last forwarded data word (receiver -> sink)
//   valid    - one-cycle strobe, data_out refreshed
//   idle     - last aligned word while locked was the idle symbol
//   active   - receiver locked
// Modports: master = bit source / word sink, slave = receiver.
interface serial_paralelo_sync_if #(
    parameter int unsigned WIDTH = 8
);

    logic             data_in;
    logic [WIDTH-1:0] data_out;
    logic             valid;
    logic             idle;
    logic             active;

    modport master (
        output data_in,
        input  data_out,
        input  valid,
        input  idle,
        input  active
    );

    modport slave (
        input  data_in,
        output data_out,
        output valid,
        output idle,
        output active
    );

endinterface

// File: rtl/sp_word_aligner.sv
// Purpose: serial shift window and word-phase counter for the receiver.
// Ports:
//   clk_32f         - bit-rate clock
//   reset           - synchronous active-high reset
//   i_data          - serial bit, shifted in at the LSB every cycle
//   i_realign       - restart phase: bit_cnt becomes 1 on this edge
//   i_hunt          - every cycle is a word candidate
//   o_word          - current WIDTH-bit window (registered)
//   o_boundary_c    - this cycle holds a candidate word
//   o_comma_hit_c   - current window equals the comma symbol
module sp_word_aligner
    import phy_pkg::*;
#(
    parameter int unsigned       WIDTH = 8,
    parameter logic [WIDTH-1:0]  COMMA = WIDTH'(COMMA_SYM)
) (
    input  logic             clk_32f,
    input  logic             reset,
    input  logic             i_data,
    input  logic             i_realign,
    input  logic             i_hunt,
    output logic [WIDTH-1:0] o_word,
    output logic             o_boundary_c,
    output logic             o_comma_hit_c
);

    localparam int unsigned      CNT_W      = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_PHASE = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] r_sr;
    logic [CNT_W-1:0] r_bit_cnt;

    // Serial window, shifts in all states.
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            r_sr <= '0;
        end else begin
            r_sr <= {r_sr[WIDTH-2:0], i_data};
        end
    end

    // Word phase; a comma detected this cycle completed on the previous
    // edge, so the restart value is 1 to land the next boundary WIDTH bits on.
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            r_bit_cnt <= '0;
        end else if (i_realign) begin
            r_bit_cnt <= CNT_W'(1);
        end else if (r_bit_cnt == LAST_PHASE) begin
            r_bit_cnt <= '0;
        end else begin
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
        end
    end

    assign o_word        = r_sr;
    assign o_boundary_c  = i_hunt | (r_bit_cnt == '0);
    assign o_comma_hit_c = (r_sr == COMMA);

endmodule

// File: rtl/serial_paralelo_sync.sv
// Purpose: serial-to-parallel receiver with comma alignment, lock
//          qualification, starvation-based loss of lock and idle flagging.
// Ports:
//   clk_32f - bit-rate clock, all logic on posedge
//   reset   - synchronous active-high reset
//   bus     - slave side of serial_paralelo_sync_if
//             (data_in in; data_out, valid, idle, active out)
module serial_paralelo_sync
    import phy_pkg::*;
#(
    parameter int unsigned       WIDTH      = 8,
    parameter logic [WIDTH-1:0]  COMMA      = WIDTH'(COMMA_SYM),
    parameter logic [WIDTH-1:0]  IDLE       = WIDTH'(IDLE_SYM),
    parameter int unsigned       LOCK_COUNT = 4,
    parameter int unsigned       MAX_GAP    = 16
) (
    input  logic                  clk_32f,
    input  logic                  reset,
    serial_paralelo_sync_if.slave bus
);

    localparam int unsigned COMMA_W = $clog2(LOCK_COUNT + 1);
    localparam int unsigned GAP_W   = $clog2(MAX_GAP + 1);

    // Elaboration-time parameter sanity.
    if (COMMA == IDLE) begin : g_bad_symbols
        $error("serial_paralelo_sync: COMMA and IDLE must differ");
    end
    if (WIDTH < 4) begin : g_bad_width
        $error("serial_paralelo_sync: WIDTH must be at least 4");
    end
    if (LOCK_COUNT < 1 || MAX_GAP < 1) begin : g_bad_counts
        $error("serial_paralelo_sync: LOCK_COUNT and MAX_GAP must be at least 1");
    end

    rx_state_t          r_state;
    rx_state_t          w_state_nxt;
    logic [COMMA_W-1:0] r_comma_cnt;
    logic [COMMA_W-1:0] w_comma_cnt_nxt;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic [GAP_W-1:0]   w_gap_cnt_nxt;
    logic [WIDTH-1:0]   r_data_out;
    logic [WIDTH-1:0]   w_data_out_nxt;
    logic               r_valid;
    logic               w_valid_nxt;
    logic               r_idle;
    logic               w_idle_nxt;
    logic               r_active;
    logic               w_active_nxt;
    logic               w_realign;
    logic               w_hunt;
    logic               w_boundary;
    logic               w_comma_hit;
    logic [WIDTH-1:0]   w_word;

    assign w_hunt = (r_state == ST_HUNT);

    sp_word_aligner #(
        .WIDTH (WIDTH),
        .COMMA (COMMA)
    ) u_aligner (
        .clk_32f       (clk_32f),
        .reset         (reset),
        .i_data        (bus.data_in),
        .i_realign     (w_realign),
        .i_hunt        (w_hunt),
        .o_word        (w_word),
        .o_boundary_c  (w_boundary),
        .o_comma_hit_c (w_comma_hit)
    );

    // State, counters and output registers.
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            r_state     <= ST_HUNT;
            r_comma_cnt <= '0;
            r_gap_cnt   <= '0;
            r_data_out  <= '0;
            r_valid     <= 1'b0;
            r_idle      <= 1'b0;
            r_active    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_comma_cnt <= w_comma_cnt_nxt;
            r_gap_cnt   <= w_gap_cnt_nxt;
            r_data_out  <= w_data_out_nxt;
            r_valid     <= w_valid_nxt;
            r_idle      <= w_idle_nxt;
            r_active    <= w_active_nxt;
        end
    end

    // Next-state and next-output decode; only boundary cycles act.
    always_comb begin
        w_state_nxt     = r_state;
        w_comma_cnt_nxt = r_comma_cnt;
        w_gap_cnt_nxt   = r_gap_cnt;
        w_data_out_nxt  = r_data_out;
        w_valid_nxt     = 1'b0;
        w_idle_nxt      = r_idle;
        w_active_nxt    = r_active;
        w_realign       = 1'b0;

        unique case (r_state)
            ST_HUNT: begin
                if (w_boundary && w_comma_hit) begin
                    w_realign       = 1'b1;
                    w_comma_cnt_nxt = COMMA_W'(1);
                    if (LOCK_COUNT == 1) begin
                        w_state_nxt   = ST_LOCKED;
                        w_gap_cnt_nxt = '0;
                        w_active_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = ST_ALIGN;
                    end
                end
            end

            ST_ALIGN: begin
                if (w_boundary) begin
                    if (w_comma_hit) begin
                        w_comma_cnt_nxt = r_comma_cnt + COMMA_W'(1);
                        if (r_comma_cnt == COMMA_W'(LOCK_COUNT - 1)) begin
                            w_state_nxt   = ST_LOCKED;
                            w_gap_cnt_nxt = '0;
                            w_active_nxt  = 1'b1;
                        end
                    end else begin
                        w_state_nxt     = ST_HUNT;
                        w_comma_cnt_nxt = '0;
                    end
                end
            end

            ST_LOCKED: begin
                if (w_boundary) begin
                    if (w_comma_hit) begin
                        // Comma classification takes priority over idle.
                        w_gap_cnt_nxt = '0;
                        w_idle_nxt    = 1'b0;
                    end else begin
                        if (w_word == IDLE) begin
                            w_idle_nxt = 1'b1;
                        end else begin
                            w_data_out_nxt = w_word;
                            w_valid_nxt    = 1'b1;
                            w_idle_nxt     = 1'b0;
                        end
                        w_gap_cnt_nxt = r_gap_cnt + GAP_W'(1);
                        // Starvation: this word is still forwarded, but lock
                        // and the idle flag drop on the same edge.
                        if (r_gap_cnt == GAP_W'(MAX_GAP - 1)) begin
                            w_state_nxt     = ST_HUNT;
                            w_active_nxt    = 1'b0;
                            w_idle_nxt      = 1'b0;
                            w_gap_cnt_nxt   = '0;
                            w_comma_cnt_nxt = '0;
                        end
                    end
                end
            end

            default: begin
                w_state_nxt     = ST_HUNT;
                w_comma_cnt_nxt = '0;
                w_gap_cnt_nxt   = '0;
                w_active_nxt    = 1'b0;
                w_idle_nxt      = 1'b0;
            end
        endcase
    end

    assign bus.data_out = r_data_out;
    assign bus.valid    = r_valid;
    assign bus.idle     = r_idle;
    assign bus.active   = r_active;

endmodule

// File: doc/serial_paralelo_sync.md
# serial_paralelo_sync

Parametrised serial-to-parallel receiver for the physical layer. It runs on a single bit-rate clock and deserialises an MSB-first bit stream into WIDTH-bit words. It finds word alignment at any bit offset by sliding-window comma search and declares lock after LOCK_COUNT consecutive aligned commas. It drops lock on comma starvation, and flags idle words. It replaces the dual-clock serial-to-parallel stage with a self-timed word strobe.

## Interface
- WIDTH, 8, word width in bits (≥4)
- COMMA, 'hBC, alignment/comma symbol (WIDTH bits)
- IDLE, 'h7C, idle symbol (WIDTH bits, ≠ COMMA)
- LOCK_COUNT, 4, consecutive aligned commas required to lock (≥1)
- MAX_GAP, 16, consecutive non-comma words tolerated in LOCKED before loss of lock (≥1)
- clk_32f  input  1  bit-rate clock; all logic on posedge
- reset  input  1  synchronous, active-high reset
- data_in  input  1  serial data, MSB first, one bit per clock
- data_out  output  WIDTH  last forwarded data word
- valid  output  1  one-cycle strobe: data_out updated with a data word
- idle  output  1  last aligned word in LOCKED equals IDLE
- active  output  1  receiver locked (state == LOCKED)

## Operation
- Shift register sr (WIDTH): every cycle sr <= {sr[WIDTH-2:0], data_in}, in all states; cleared by reset.
- Phase counter bit_cnt (0..WIDTH-1) increments every cycle and wraps WIDTH-1→0. A boundary is any cycle with bit_cnt == 0 in ALIGN/LOCKED. In HUNT, every cycle is treated as a candidate.
- comma_cnt counts aligned commas (0..LOCK_COUNT). gap_cnt counts consecutive non-comma words ($clog2(MAX_GAP+1) bits).
- FSM states: HUNT, ALIGN, LOCKED. Reset → HUNT, all counters 0.
- HUNT: when sr == COMMA, set bit_cnt <= 1 and comma_cnt <= 1. Go to LOCKED if LOCK_COUNT == 1, else go to ALIGN. Otherwise stay in HUNT.
- ALIGN, at a boundary:
  - sr == COMMA: comma_cnt++. On reaching LOCK_COUNT → LOCKED with gap_cnt <= 0.
  - any other word: → HUNT, comma_cnt <= 0.
  - Between boundaries: hold.
- LOCKED, at a boundary:
  - sr == COMMA: gap_cnt <= 0; valid stays 0; idle <= 0.
  - sr == IDLE: idle <= 1; valid stays 0; gap_cnt++.
  - any other word: data_out <= sr, valid <= 1, idle <= 0, gap_cnt++.
  - If a non-comma word arrives with gap_cnt == MAX_GAP-1 → HUNT. That word is still forwarded (valid or idle as above) on that edge, and active deasserts on the same edge.
- Commas seen off-boundary while in ALIGN/LOCKED are ignored.
- Leaving LOCKED: active <= 0, idle <= 0 on the transition edge. data_out holds its last value.
- Outputs update only as stated; all other cycles hold, except valid, which is 0 on every cycle it is not strobed.

## Timing
- Reset values: data_out = 0, valid = 0, idle = 0, active = 0, state HUNT, sr = 0, bit_cnt = 0.
- Reset is synchronous and wins over every other event, including a boundary on the same edge. Mid-word reset discards the partial word and lock.
- Latency: last bit of a word sampled at edge N; valid/data_out/idle reflect it after edge N+1. valid is high for exactly one cycle.
- Comma whose last bit is sampled at edge N in HUNT: the next boundary is the cycle after edge N+WIDTH.
- Lock time: with the first comma ending at edge N and back-to-back commas, active rises after edge N+(LOCK_COUNT-1)·WIDTH+1.
- Valid strobes are spaced at least WIDTH cycles apart.
- Loss of lock: active falls one cycle after the last bit of the MAX_GAP-th consecutive non-comma word.
- COMMA wins over IDLE classification; they must differ (parameter check).

## Structure
- Shared package phy_pkg: state encoding (HUNT, ALIGN, LOCKED), default COMMA_SYM = 8'hBC and IDLE_SYM = 8'h7C.
- One sub-module, sp_word_aligner: holds sr and bit_cnt, and produces the boundary and comma_hit signals. Its inputs are realign (sets bit_cnt to 1) and hunt (every cycle is a candidate).
- The top level holds the FSM, comma_cnt, gap_cnt and output registers.

## Test plan
- Defaults; 3 junk bits, then BC×4, then 0x5A → active rises 1 cycle after the 4th BC ends; one valid pulse with data_out = 0x5A, WIDTH cycles later.
- BC×3, then 0x12 → state returns to HUNT; active stays 0; no valid pulse.
- Locked; send 0x7C, then 0x33 → idle = 1 with no valid, then idle = 0 with valid and data_out = 0x33.
- Locked; 15 data words then BC → active stays 1. Locked; 16 data words → active falls after the 16th word; that 16th word still gives one valid pulse.
- Locked; assert reset for one cycle mid-word → all outputs 0 next cycle; relock requires 4 fresh BC.
- WIDTH = 10, COMMA = 10'h17C, IDLE = 10'h283, LOCK_COUNT = 1 → locks on the first comma at any bit offset; data words are forwarded every 10 cycles.
